// File: rtl/board_scanner_if.sv
// board_scanner_if -- scan handshake and board RAM read port.
//   start      : scan request (master -> slave)
//   rd_addr    : board RAM read address, cell = col + 7*row (slave -> master)
//   rd_data    : board RAM q, valid one cycle after rd_addr (master -> slave)
//   busy, done : scan in progress / one-cycle results-valid pulse
//   winner     : 00 none, 01 player 1, 10 player 2, 11 both
//   board_full : all 42 cells hold a player piece
//   p1_count, p2_count : pieces per player from the last scan
interface board_scanner_if;
   logic       start;
   logic [5:0] rd_addr;
   logic [1:0] rd_data;
   logic       busy;
   logic       done;
   logic [1:0] winner;
   logic       board_full;
   logic [5:0] p1_count;
   logic [5:0] p2_count;

   modport slave (
      input  start, rd_data,
      output rd_addr, busy, done, winner, board_full, p1_count, p2_count
   );

   modport master (
      output start, rd_data,
      input  rd_addr, busy, done, winner, board_full, p1_count, p2_count
   );
endinterface

// File: rtl/board_scanner.sv
// board_scanner -- reads a 7x6 four-in-a-row board out of RAM into a shadow
// copy, then evaluates every length-4 window in a single cycle.
//   CLOCK_50 : clock, rising edge
//   reset    : asynchronous active-high reset
//   bus      : board_scanner_if.slave (start, rd_addr/rd_data, busy, done,
//              winner, board_full, p1_count, p2_count)
// Optional feature: define DIAG_CHECK_EN to include the 24 diagonal windows.
// Timeline after the start edge: READ cycles 1..43 (address k in cycle k+1,
// data captured at end of cycle k+2), EVAL cycle 44, DONE (done=1) cycle 45.
module board_scanner (
   input logic             CLOCK_50,
   input logic             reset,
   board_scanner_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_t;

   state_t           state;
   logic [5:0]       cnt;       // READ cycle index: cycle j of the scan has cnt = j-1
   logic [41:0][1:0] board_q;
   logic [5:0]       p1_acc;
   logic [5:0]       p2_acc;
   logic [1:0]       hits;      // bit0 player 1 has a four, bit1 player 2
   logic             full_c;

   // Returns {player 2 four, player 1 four} for the window starting at cell i
   // with stride s. Encoding 11 matches neither player.
   function automatic logic [1:0] win_at(input logic [41:0][1:0] b,
                                         input int i, input int s);
      logic [1:0] a0, a1, a2, a3;
      a0 = b[6'(i)];
      a1 = b[6'(i + s)];
      a2 = b[6'(i + 2*s)];
      a3 = b[6'(i + 3*s)];
      win_at[0] = (a0 == 2'b01) && (a1 == 2'b01) && (a2 == 2'b01) && (a3 == 2'b01);
      win_at[1] = (a0 == 2'b10) && (a1 == 2'b10) && (a2 == 2'b10) && (a3 == 2'b10);
   endfunction

   always_comb begin
      hits   = 2'b00;
      full_c = 1'b1;
      for (int i = 0; i < 42; i++)
         if (!(board_q[i] == 2'b01 || board_q[i] == 2'b10)) full_c = 1'b0;
      // horizontal: 6 rows x 4 start columns
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 4; c++)
            hits |= win_at(board_q, 7*r + c, 1);
      // vertical: 3 start rows x 7 columns
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 7; c++)
            hits |= win_at(board_q, 7*r + c, 7);
`ifdef DIAG_CHECK_EN
      // down-right from columns 0..3, down-left from columns 3..6
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++)
            hits |= win_at(board_q, 7*r + c, 8);
      for (int r = 0; r < 3; r++)
         for (int c = 3; c < 7; c++)
            hits |= win_at(board_q, 7*r + c, 6);
`else
`endif
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= 6'd0;
         board_q        <= '0;
         p1_acc         <= 6'd0;
         p2_acc         <= 6'd0;
         bus.rd_addr    <= 6'd0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.winner     <= 2'b00;
         bus.board_full <= 1'b0;
         bus.p1_count   <= 6'd0;
         bus.p2_count   <= 6'd0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // DONE accepts start too, so scans can run back to back
               if (bus.start) begin
                  state       <= READ;
                  cnt         <= 6'd0;
                  bus.rd_addr <= 6'd0;
                  bus.busy    <= 1'b1;
                  p1_acc      <= 6'd0;
                  p2_acc      <= 6'd0;
               end else begin
                  state <= IDLE;
               end
            end
            READ: begin
               cnt         <= cnt + 6'd1;
               bus.rd_addr <= (cnt < 6'd41) ? cnt + 6'd1 : 6'd0;
               // data for address cnt-1 arrives while cnt is presented
               if (cnt != 6'd0) begin
                  board_q[cnt - 6'd1] <= bus.rd_data;
                  if (bus.rd_data == 2'b01) p1_acc <= p1_acc + 6'd1;
                  if (bus.rd_data == 2'b10) p2_acc <= p2_acc + 6'd1;
               end
               if (cnt == 6'd42) state <= EVAL;
            end
            EVAL: begin
               bus.winner     <= hits;
               bus.board_full <= full_c;
               bus.p1_count   <= p1_acc;
               bus.p2_count   <= p2_acc;
               bus.busy       <= 1'b0;
               bus.done       <= 1'b1;
               state          <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 SHALL have port CLOCK_50, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, scan request, sampled on the rising edge.
REQ-004 SHALL have port rd_addr, output, 6, board RAM read address; cell = col + 7*row, row 0 is the top row.
REQ-005 SHALL have port rd_data, input, 2, board RAM q, valid one cycle after rd_addr is presented.
REQ-006 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-007 SHALL have port done, output, 1, one-cycle pulse when the results are valid.
REQ-008 SHALL have port winner, output, 2: 00 none, 01 player 1, 10 player 2, 11 both players have four in a row.
REQ-009 SHALL have port board_full, output, 1, all 42 cells are occupied.
REQ-010 SHALL have ports p1_count and p2_count, output, 6 each, pieces counted per player.

Function
REQ-011 Cell encoding SHALL be 00 empty, 01 player 1, 10 player 2; 11 SHALL be treated as empty.
REQ-012 The FSM SHALL have states IDLE, READ, EVAL and DONE.
REQ-013 IDLE SHALL go to READ when start=1; otherwise it SHALL hold.
REQ-014 READ SHALL drive rd_addr = k during cycle k+1 after the start edge, for k = 0..41.
REQ-015 READ SHALL capture rd_data in cycle k+2 into shadow cell k, adding 1 to the matching player count.
REQ-016 READ SHALL go to EVAL after shadow cell 41 is captured at the end of cycle 43.
REQ-017 EVAL SHALL last exactly one cycle (cycle 44) and SHALL check every length-4 window of the 7x6 shadow board.
REQ-018 Windows checked SHALL be 24 horizontal, 21 vertical and, when diagonals are enabled, 12 down-right and 12 down-left.
REQ-019 winner, board_full and the counts SHALL be registered at the end of EVAL.
REQ-020 DONE SHALL assert done=1 in cycle 45 and return to IDLE the next cycle.
REQ-021 busy SHALL be 1 in cycles 1..44 and 0 otherwise.
REQ-022 Scan latency SHALL be exactly 45 cycles from the start edge to done.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 start=1 during the DONE cycle SHALL begin a new scan, with cycle 1 following.
REQ-025 winner, board_full and the counts SHALL hold until the end of the next EVAL or until reset.
REQ-026 Counts SHALL be cleared at scan start; the maximum count is 42, so no overflow is possible.
REQ-027 rd_addr SHALL be 0 outside READ.
REQ-028 A player SHALL be flagged in winner when any window holds four of that player's cells; if both players are flagged, winner SHALL be 11.
REQ-029 board_full SHALL be 1 iff every cell is nonzero and not 11, independent of winner.

Reset
REQ-030 Reset SHALL force state IDLE and clear the shadow board.
REQ-031 Under reset, all outputs SHALL be 0: rd_addr=0, busy=0, done=0, winner=00, board_full=0, both counts 0.
REQ-032 Reset asserted mid-scan SHALL abort the scan with no done pulse.
REQ-033 After reset deasserts, the first start SHALL produce a full 45-cycle scan.

Configuration
REQ-034 When macro DIAG_CHECK_EN is defined, the 24 diagonal windows SHALL be included in EVAL.
REQ-035 When DIAG_CHECK_EN is undefined, only the horizontal and vertical windows SHALL be checked, and a diagonal-only four SHALL give winner=00; all timing SHALL be unchanged.

Verification
REQ-036 Empty board, start -> done in cycle 45, winner=00, board_full=0, counts 0/0, busy high in cycles 1..44.
REQ-037 Player 1 at cells 35,36,37,38 (bottom row) -> winner=01, p1_count=4.
REQ-038 Player 2 at cells 38,30,22,14 (diagonal) -> winner=10 with DIAG_CHECK_EN defined, 00 without it.
REQ-039 Full board, no four, 21 pieces each -> winner=00, board_full=1, counts 21/21; adding a player 1 and a player 2 four to the board -> winner=11.
REQ-040 Reset pulsed in cycle 20, then start -> no done in the aborted scan; the new scan's done arrives 45 cycles after the new start; start pulses during busy have no effect.
